// File: rtl/axis_sram_wr_fifo.sv
// AXI4-Stream ingress FIFO for the SRAM output queue: each beat becomes one {sop,eop,meta,strb,data} word.
// Define SRAM_OQ_STORE_FWD_EN to expose only complete packets to the reader (store-and-forward).
module axis_sram_wr_fifo #(
  parameter int DATA_WIDTH    = 256,
  parameter int USER_WIDTH    = 128,
  parameter int META_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 9,
  parameter int AEMPTY_THRESH = 4,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int WORD_WIDTH    = 2 + META_WIDTH + STRB_WIDTH + DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cal_done,
  input  logic                  tvalid,
  output logic                  tready,
  input  logic [DATA_WIDTH-1:0] tdata,
  input  logic [STRB_WIDTH-1:0] tstrb,
  input  logic                  tlast,
  input  logic [USER_WIDTH-1:0] tuser,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  dout_valid,
  output logic [WORD_WIDTH-1:0] dout,
  output logic [31:0]           word_cnt,
  output logic [31:0]           pkt_cnt,
  output logic                  oversize_err
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;

  typedef enum logic {S_IDLE, S_IN_PKT} state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]         readable_d;
  logic [31:0]           word_cnt_q, word_cnt_d, pkt_cnt_q, pkt_cnt_d;
  logic                  full_q, full_d, empty_q, empty_d, aempty_q, aempty_d;
  logic                  dout_valid_q, dout_valid_d, oversize_q, oversize_d;
  logic [WORD_WIDTH-1:0] dout_q;
  logic [WORD_WIDTH-1:0] mem [DEPTH];
  logic                  eop_mem [DEPTH];
  logic                  wr_fire, rd_fire, sop;
  logic [META_WIDTH-1:0] meta;
  logic [WORD_WIDTH-1:0] wr_word;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
`ifdef SRAM_OQ_STORE_FWD_EN
  logic                  cut_q, cut_d;
`endif

  if (USER_WIDTH > META_WIDTH) begin : g_user_hi
    logic unused_user_hi;
    assign unused_user_hi = ^tuser[USER_WIDTH-1:META_WIDTH];
  end

  // Held low through reset so no beat can be taken while state is being cleared.
  assign tready  = cal_done & resetn & ~full_q;
  assign wr_fire = tvalid & tready;
  assign rd_fire = rd_en & ~empty_q;
  assign sop     = (state_q == S_IDLE);
  assign meta    = sop ? tuser[META_WIDTH-1:0] : '0;
  assign wr_word = {sop, tlast, meta, tstrb, tdata};
  assign wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
  assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    if (wr_fire) state_d = tlast ? S_IDLE : S_IN_PKT;
    wr_ptr_d     = wr_ptr_q + PW'(wr_fire);
    rd_ptr_d     = rd_ptr_q + PW'(rd_fire);
    word_cnt_d   = word_cnt_q + 32'(wr_fire) - 32'(rd_fire);
    pkt_cnt_d    = pkt_cnt_q + 32'(wr_fire & tlast) - 32'(rd_fire & eop_mem[rd_addr]);
    full_d       = (word_cnt_d == 32'(DEPTH));
    commit_ptr_d = commit_ptr_q;
    oversize_d   = 1'b0;
`ifdef SRAM_OQ_STORE_FWD_EN
    cut_d = cut_q;
    if (wr_fire && (tlast || cut_q)) begin
      commit_ptr_d = wr_ptr_q + PW'(1);
    end else if (full_q && (commit_ptr_q == rd_ptr_q)) begin
      // Packet bigger than the whole FIFO: release it and stream the rest through.
      commit_ptr_d = wr_ptr_q;
      oversize_d   = 1'b1;
      cut_d        = 1'b1;
    end
    if (wr_fire && tlast) cut_d = 1'b0;
`else
    commit_ptr_d = wr_ptr_d;
`endif
    readable_d   = commit_ptr_d - rd_ptr_d;
    empty_d      = (readable_d == '0);
    aempty_d     = (32'(readable_d) <= 32'(AEMPTY_THRESH));
    dout_valid_d = rd_fire;
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_addr]     <= wr_word;
      eop_mem[wr_addr] <= tlast;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout_q <= '0;
    end else if (rd_fire) begin
      dout_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      commit_ptr_q <= '0;
      word_cnt_q   <= '0;
      pkt_cnt_q    <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      aempty_q     <= 1'b1;
      dout_valid_q <= 1'b0;
      oversize_q   <= 1'b0;
`ifdef SRAM_OQ_STORE_FWD_EN
      cut_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      word_cnt_q   <= word_cnt_d;
      pkt_cnt_q    <= pkt_cnt_d;
      full_q       <= full_d;
      empty_q      <= empty_d;
      aempty_q     <= aempty_d;
      dout_valid_q <= dout_valid_d;
      oversize_q   <= oversize_d;
`ifdef SRAM_OQ_STORE_FWD_EN
      cut_q        <= cut_d;
`endif
    end
  end

  assign empty        = empty_q;
  assign almost_empty = aempty_q;
  assign dout_valid   = dout_valid_q;
  assign dout         = dout_q;
  assign word_cnt     = word_cnt_q;
  assign pkt_cnt      = pkt_cnt_q;
  assign oversize_err = oversize_q;

endmodule

// File: tb/tb_axis_sram_wr_fifo.sv
// Scoreboard bench for axis_sram_wr_fifo: a count-based packet model predicts every output each cycle.
module tb_axis_sram_wr_fifo;
  localparam int DW = 32, UW = 24, MW = 16, AW = 4, TH = 4;
  localparam int SW = DW / 8, WW = 2 + MW + SW + DW, DEPTH = 1 << AW;
`ifdef SRAM_OQ_STORE_FWD_EN
  localparam bit SF = 1'b1;
`else
  localparam bit SF = 1'b0;
`endif

  logic          clk = 1'b0, resetn = 1'b0, cal_done = 1'b0;
  logic          tvalid = 1'b0, tlast = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] tdata = '0;
  logic [SW-1:0] tstrb = '0;
  logic [UW-1:0] tuser = '0;
  logic          tready, empty, almost_empty, dout_valid, oversize_err;
  logic [WW-1:0] dout;
  logic [31:0]   word_cnt, pkt_cnt;

  always #5 clk = ~clk;

  axis_sram_wr_fifo #(
    .DATA_WIDTH(DW), .USER_WIDTH(UW), .META_WIDTH(MW), .ADDR_WIDTH(AW), .AEMPTY_THRESH(TH)
  ) dut (
    .clk(clk), .resetn(resetn), .cal_done(cal_done), .tvalid(tvalid), .tready(tready),
    .tdata(tdata), .tstrb(tstrb), .tlast(tlast), .tuser(tuser), .rd_en(rd_en),
    .empty(empty), .almost_empty(almost_empty), .dout_valid(dout_valid), .dout(dout),
    .word_cnt(word_cnt), .pkt_cnt(pkt_cnt), .oversize_err(oversize_err)
  );

  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain counts of words written, read and released to the reader.
  int nw = 0, nr = 0, ncommit = 0, npkt = 0, n_acc = 0, n_out = 0, dut_ovs = 0;
  bit in_pkt = 0, cut = 0, dv_exp = 0, ovs_exp = 0, beat_taken = 0;
  logic [WW-1:0] exp_q[$];
  bit            eop_q[$];
  int            rd_mode = 0;

  always @(negedge clk) begin
    bit tr_exp, acc, rda;
    logic [MW-1:0] meta_e;
    if (!resetn) begin
      nw = 0; nr = 0; ncommit = 0; npkt = 0; n_acc = 0; n_out = 0;
      in_pkt = 0; cut = 0; dv_exp = 0; ovs_exp = 0; beat_taken = 0;
      exp_q.delete(); eop_q.delete();
      chk("rst_tready", tready, 0);
      chk("rst_empty", empty, 1);
      chk("rst_almost_empty", almost_empty, 1);
      chk("rst_word_cnt", word_cnt, 0);
      chk("rst_pkt_cnt", pkt_cnt, 0);
      chk("rst_dout_valid", dout_valid, 0);
      chk("rst_dout", dout, 0);
      chk("rst_oversize", oversize_err, 0);
    end else begin
      tr_exp = cal_done && (nw - nr < DEPTH);
      chk("tready", tready, tr_exp);
      chk("word_cnt", word_cnt, nw - nr);
      chk("pkt_cnt", pkt_cnt, npkt);
      chk("empty", empty, ncommit == nr);
      chk("almost_empty", almost_empty, (ncommit - nr) <= TH);
      chk("dout_valid", dout_valid, dv_exp);
      chk("oversize_err", oversize_err, ovs_exp);
      acc = tvalid && tr_exp;
      rda = rd_en && (ncommit != nr);
      ovs_exp = 0;
      if (SF && !cut && (nw - nr == DEPTH) && (ncommit == nr)) begin
        ncommit = nw; cut = 1; ovs_exp = 1;
      end
      if (acc) begin
        meta_e = in_pkt ? '0 : tuser[MW-1:0];
        exp_q.push_back({!in_pkt, tlast, meta_e, tstrb, tdata});
        eop_q.push_back(tlast);
        nw++; n_acc++;
        if (tlast) npkt++;
        if (!SF || cut || tlast) ncommit = nw;
        if (tlast) cut = 0;
        in_pkt = !tlast;
      end
      if (rda) begin
        if (eop_q.pop_front()) npkt--;
        nr++;
      end
      dv_exp = rda;
      beat_taken = acc;
    end
  end

  // Monitor: every presented word must be the oldest outstanding expected word.
  always @(negedge clk) begin
    logic [WW-1:0] e;
    if (resetn && oversize_err) dut_ovs++;
    if (resetn && dout_valid) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL dout_unexpected: got %0h expected no word", dout);
      end else begin
        e = exp_q.pop_front();
        chk("dout", dout, e);
        n_out++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #2;
      rd_en = (rd_mode == 2) || ((rd_mode == 1) && ($urandom_range(0, 1) == 1));
    end
  end

  // Sends one packet; abort_at < len stops after that many beats, leaving it unfinished.
  task automatic send_pkt(input int len, input int idle_pct, input logic [UW-1:0] u, input int abort_at);
    for (int b = 0; b < len; b++) begin
      int waited = 0;
      if (b == abort_at) begin tvalid = 1'b0; return; end
      tdata = DW'($urandom);
      tstrb = SW'($urandom);
      tuser = (b == 0) ? u : UW'($urandom);
      tlast = (b == len - 1);
      forever begin
        tvalid = ($urandom_range(0, 99) >= idle_pct);
        @(posedge clk);
        if (beat_taken) break;
        waited++;
        if (waited > 2000) begin
          total++; bad++;
          $display("FAIL send_timeout: beat %0d waited %0d cycles, required <= 2000", b, waited);
          tvalid = 1'b0;
          return;
        end
        #1;
      end
      #1;
    end
    tvalid = 1'b0;
  endtask

  task automatic drain(input string name);
    int c = 0;
    rd_mode = 1;
    while ((nr != nw || exp_q.size() != 0) && c < 3000) begin @(posedge clk); c++; end
    #1;
    if (c >= 3000) begin
      total++; bad++;
      $display("FAIL %s_drain: %0d words left, required 0", name, nw - nr);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1; resetn = 1'b1; cal_done = 1'b1;
    @(posedge clk); #1;

    // Single 4-beat packet, read back after it is fully stored.
    send_pkt(4, 0, UW'(24'hAB1234), 99);
    repeat (2) @(posedge clk);
    @(negedge clk); chk("A_pkt_cnt", pkt_cnt, 1); chk("A_word_cnt", word_cnt, 4);
    @(posedge clk); #1;
    drain("A");
    @(negedge clk); chk("A_pkt_cnt_after", pkt_cnt, 0); chk("A_words_out", n_out, 4);
    @(posedge clk); #1;

    // Ingress blocked while calibration is incomplete.
    cal_done = 1'b0;
    fork
      send_pkt(3, 0, UW'($urandom), 99);
      begin repeat (10) @(posedge clk); #1; cal_done = 1'b1; end
    join
    drain("B");

    // Fill to DEPTH with no reads, then one read reopens ingress.
    rd_mode = 0;
    fork
      begin send_pkt(16, 0, UW'($urandom), 99); send_pkt(2, 0, UW'($urandom), 99); end
      begin
        repeat (20) @(posedge clk);
        @(negedge clk); chk("C_full_word_cnt", word_cnt, 16); chk("C_full_tready", tready, 0);
        @(posedge clk); #1; rd_mode = 2;
        @(posedge clk); #1; rd_mode = 0;
        @(negedge clk); chk("C_tready_reopen", tready, 1);
        repeat (4) @(posedge clk); #1; rd_mode = 1;
      end
    join
    drain("C");

    // 20-beat packet longer than the FIFO.
    rd_mode = 0; dut_ovs = 0;
    fork
      send_pkt(20, 0, UW'($urandom), 99);
      begin repeat (30) @(posedge clk); #1; rd_mode = 1; end
    join
    drain("D");
    chk("D_oversize_pulses", dut_ovs, SF ? 1 : 0);

    // Reset in the middle of a packet, then a fresh packet must start with sop.
    send_pkt(5, 0, UW'($urandom), 2);
    #1; resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1; resetn = 1'b1;
    @(negedge clk); chk("E_empty", empty, 1); chk("E_word_cnt", word_cnt, 0);
    @(posedge clk); #1;
    send_pkt(3, 0, UW'(24'h00BEEF), 99);
    drain("E");
    chk("E_words_out", n_out, 3);

    // Randomized traffic with random reads and calibration drops.
    fork
      for (int p = 0; p < 40; p++) send_pkt($urandom_range(1, 24), 30, UW'($urandom), 99);
      begin
        rd_mode = 1;
        repeat (60) begin
          repeat ($urandom_range(5, 20)) @(posedge clk);
          #1; cal_done = ($urandom_range(0, 3) != 0);
        end
        #1; cal_done = 1'b1;
      end
    join
    cal_done = 1'b1;
    drain("F");
    @(negedge clk);
    chk("F_final_empty", empty, 1);
    chk("F_words_out", n_out, n_acc);
    chk("F_final_pkt_cnt", pkt_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
